conversor_bcd_seq: RTL
======================

Name: conversor_bcd_seq

Overview:
Multi-cycle, parametrised binary-to-BCD converter for the I/O module: one shift-and-add-3 iteration per clock instead of a fully unrolled combinational chain.
Adds start/done handshake, signed (two's-complement) mode, leading-zero blanking and overflow detection for arbitrary width and digit count.
Drives the 7-segment decoders of the I/O path.
Blank code 4'hA on any digit means "display off".

Parameters:
WIDTH, 32, binary input width (>=4)
DIGITS, 10, number of BCD digits produced (10 covers full 32-bit unsigned range)
BLANK_CODE, 4'hA, code driven on blanked/disabled digits

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
enable  input  1  0 forces every bcd digit to BLANK_CODE (output mask only, FSM keeps running)
start  input  1  request conversion; accepted only when ready=1
binario  input  WIDTH  value to convert, sampled on accepted start
signed_mode  input  1  1 = treat binario as two's complement, sampled with start
blank_lz  input  1  1 = replace leading zero digits by BLANK_CODE, sampled with start
ready  output  1  1 in IDLE
busy  output  1  1 from LOAD through FINISH
done  output  1  one-cycle pulse when new results are valid
bcd  output  4*DIGITS  digit k at bits [4k+3:4k], digit 0 = ones
negative  output  1  result sign (1 only in signed_mode with binario[WIDTH-1]=1)
overflow  output  1  magnitude needs more than DIGITS digits

Behaviour:
- Reset (async assert, sync-free deassert): state IDLE, ready=1, busy=0, done=0, negative=0, overflow=0, result register all BLANK_CODE.
- Reset mid-conversion aborts; outputs return to reset values; no done pulse.
- FSM: IDLE -> LOAD on start&ready; LOAD -> SHIFT; SHIFT stays WIDTH cycles (bit counter WIDTH-1 down to 0) -> FINISH; FINISH -> IDLE.
- LOAD: shift reg <= |binario| (negate if signed_mode & MSB); sign latched; digit accumulators cleared; ovf sticky cleared.
- Absolute value of -2^(WIDTH-1) is 2^(WIDTH-1), held in WIDTH unsigned bits; no special case.
- SHIFT, each cycle: every digit >=5 gets +3 (4-bit), then whole {digits, shift reg} shifts left 1. A 1 shifted out of digit DIGITS-1 sets the ovf sticky.
- FINISH: apply blank_lz (digits above the highest nonzero digit -> BLANK_CODE; digit 0 never blanked, so value 0 shows "0"). Load result register, negative, overflow; done=1 this cycle.
- Latency: start sampled at edge N -> done high in cycle N+WIDTH+2. Outputs held until next FINISH.
- On overflow, bcd holds the low DIGITS digits (truncated); overflow=1.
- start while busy: ignored, no queuing. start in FINISH cycle ignored (ready=0).
- Inputs sampled only at accept; later binario changes have no effect on the current conversion.
- enable=0: bcd = all BLANK_CODE combinationally; negative/overflow/done unaffected.

Decomposition:
- Package conversor_pkg:
  - state enum (IDLE, LOAD, SHIFT, FINISH)
  - default BLANK_CODE
  - ADD3_THRESHOLD = 5
  - helper function for counter width clog2(WIDTH)
- Sub-module bcd_digit_cell: one 4-bit digit, add-3 compare plus shift with carry-in/carry-out. Instantiated DIGITS times via generate.

Test Plan:
- WIDTH=32, unsigned 0xFFFFFFFF -> bcd 4,2,9,4,9,6,7,2,9,5 (MSD..LSD), overflow=0, done exactly 34 cycles after start.
- signed_mode=1, binario=0xFFFFFFFF -> bcd=...0001, negative=1. binario=0x80000000 -> 2147483648, negative=1.
- blank_lz=1, binario=305 -> digits 9..3 = 4'hA, digits 2..0 = 3,0,5. binario=0 -> digits 9..1 = 4'hA, digit 0 = 0.
- WIDTH=16, DIGITS=4, binario=12345 -> overflow=1, bcd=2,3,4,5. binario=9999 -> overflow=0.
- start pulsed again while busy -> ignored, single done. reset_n low at SHIFT cycle 10 -> immediate reset values, no done.
- enable=0 after a completed conversion of 42 -> bcd all 4'hA. enable=1 -> 42 reappears without a new start.

Source files
------------

// File: rtl/conversor_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package conversor_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SHIFT  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [3:0] BLANK_CODE_DEF = 4'hA;
  localparam logic [3:0] ADD3_THRESHOLD = 4'd5;

  // Bit-counter width; keeps at least one bit for tiny widths.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/conversor_bcd_seq_digit.sv
// One BCD digit of the shift-and-add-3 chain: conditional +3, then shift left
// with the carry entering at the LSB and the adjusted MSB leaving as carry_out.
module bcd_digit_cell
  import conversor_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       shift_en,
  input  logic       carry_in,
  output logic       carry_out,
  output logic [3:0] digit
);

  logic [3:0] adj;

  always_comb begin
    adj = (digit >= ADD3_THRESHOLD) ? digit + 4'd3 : digit;
  end

  assign carry_out = adj[3];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      digit <= '0;
    end else if (clear) begin
      digit <= '0;
    end else if (shift_en) begin
      digit <= {adj[2:0], carry_in};
    end
  end

endmodule

// File: rtl/conversor_bcd_seq.sv
// Multi-cycle binary-to-BCD converter (one double-dabble step per clock) with
// start/done handshake, signed mode, leading-zero blanking and overflow flag.
module conversor_bcd_seq
  import conversor_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DIGITS     = 10,
  parameter logic [3:0]  BLANK_CODE = BLANK_CODE_DEF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  start,
  input  logic [WIDTH-1:0]      binario,
  input  logic                  signed_mode,
  input  logic                  blank_lz,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  negative,
  output logic                  overflow
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t              state;
  logic [WIDTH-1:0]    bin_q;
  logic [WIDTH-1:0]    shreg;
  logic                sgn_q;
  logic                blank_q;
  logic                neg_q;
  logic                ovf_st;
  logic [CW-1:0]       cnt;
  logic [4*DIGITS-1:0] acc;
  logic [4*DIGITS-1:0] blanked;
  logic [4*DIGITS-1:0] result;
  logic [DIGITS:0]     carry;
  logic                shift_en;
  logic                clear;

  assign shift_en = (state == SHIFT);
  assign clear    = (state == LOAD);
  assign carry[0] = shreg[WIDTH-1];

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit_cell u_cell (
      .clock     (clock),
      .reset_n   (reset_n),
      .clear     (clear),
      .shift_en  (shift_en),
      .carry_in  (carry[k]),
      .carry_out (carry[k+1]),
      .digit     (acc[4*k +: 4])
    );
  end

  // Scan from the most significant digit down; digit 0 is never blanked.
  always_comb begin
    int unsigned i;
    logic        seen;
    blanked = acc;
    seen    = 1'b0;
    i       = 0;
    for (int unsigned j = 0; j < DIGITS - 1; j++) begin
      i = DIGITS - 1 - j;
      if (acc[4*i +: 4] != 4'd0) begin
        seen = 1'b1;
      end else if (!seen && blank_q) begin
        blanked[4*i +: 4] = BLANK_CODE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      negative <= 1'b0;
      overflow <= 1'b0;
      result   <= {DIGITS{BLANK_CODE}};
      bin_q    <= '0;
      shreg    <= '0;
      sgn_q    <= 1'b0;
      blank_q  <= 1'b0;
      neg_q    <= 1'b0;
      ovf_st   <= 1'b0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_q   <= binario;
            sgn_q   <= signed_mode;
            blank_q <= blank_lz;
            neg_q   <= signed_mode & binario[WIDTH-1];
            state   <= LOAD;
            ready   <= 1'b0;
            busy    <= 1'b1;
          end
        end
        LOAD: begin
          shreg  <= (sgn_q && bin_q[WIDTH-1]) ? (~bin_q + 1'b1) : bin_q;
          ovf_st <= 1'b0;
          cnt    <= CW'(WIDTH - 1);
          state  <= SHIFT;
        end
        SHIFT: begin
          shreg <= shreg << 1;
          if (carry[DIGITS]) begin
            ovf_st <= 1'b1;
          end
          if (cnt == '0) begin
            state <= FINISH;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        FINISH: begin
          result   <= blanked;
          negative <= neg_q;
          overflow <= ovf_st;
          done     <= 1'b1;
          state    <= IDLE;
          ready    <= 1'b1;
          busy     <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bcd = enable ? result : {DIGITS{BLANK_CODE}};

endmodule
